// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer holding the architectural HI/LO registers.
// Latency: MULT_CYCLES / DIV_CYCLES edges from accept to HI/LO commit; backpressure via stall_md to hazard logic.
// Starts while busy are dropped; the hazard stall keeps correct code from issuing them.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start_E,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;

    logic        is_long;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_long = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU) ||
                     (md_op_E == OP_DIV)  || (md_op_E == OP_DIVU);
    assign is_div  = (md_op_E == OP_DIV)  || (md_op_E == OP_DIVU);

    // Sign-extend to 64 bits so a plain unsigned multiply yields the signed product.
    assign prod_s = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
    assign prod_u = {32'b0, rs_E} * {32'b0, rt_E};

    // One unsigned divider serves both; signed div runs on magnitudes then fixes signs.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign dvd = (md_op_E == OP_DIV && rs_E[31]) ? (32'd0 - rs_E) : rs_E;
    assign dvs = (md_op_E == OP_DIV && rt_E[31]) ? (32'd0 - rt_E) : rt_E;
    assign uq  = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    assign ur  = (dvs == 32'd0) ? 32'd0 : dvd % dvs;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op_E)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (rt_E == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = rs_E;
                end else if (md_op_E == OP_DIV) begin
                    res_lo = (rs_E[31] ^ rt_E[31]) ? (32'd0 - uq) : uq;
                    res_hi = rs_E[31] ? (32'd0 - ur) : ur;
                end else begin
                    res_lo = uq;
                    res_hi = ur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_E) begin
                        if (is_long) begin
                            pending_hi <= res_hi;
                            pending_lo <= res_lo;
                            cnt        <= is_div ? DIV_N : MULT_N;
                            state      <= RUN;
                        end else if (md_op_E == OP_MTHI) begin
                            hi <= rs_E;
                        end else if (md_op_E == OP_MTLO) begin
                            lo <= rs_E;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign stall_md = md_use_D & (busy | (md_start_E & is_long));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic corner cases, stall timing, async reset.
module tb_md_unit_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        md_start_E;
    logic [2:0]  md_op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .md_start_E(md_start_E), .md_op_E(md_op_E),
        .rs_E(rs_E), .rt_E(rt_E), .md_use_D(md_use_D), .busy(busy),
        .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start for a single edge, returns 1ns after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start_E = 1'b1; md_op_E = op; rs_E = a; rt_E = b;
        tick();
        md_start_E = 1'b0; md_op_E = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; md_start_E = 1'b0; md_op_E = 3'd0; rs_E = '0; rt_E = '0; md_use_D = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_md); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        for (int k = 0; k < 5; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d]: got %b want 1", k, busy); end
            checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_hi_early[%0d]: got %h want 0", k, hi); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_divu_stall();
        md_use_D = 1'b1;
        md_start_E = 1'b1; md_op_E = 3'd4; rs_E = 32'd100; rt_E = 32'd7;
        #1;
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL divu_stall_start: got %b want 1", stall_md); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_start: got %b want 0", busy); end
        tick();
        md_start_E = 1'b0; md_op_E = 3'd0;
        for (int k = 0; k < 10; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy[%0d]: got %b want 1", k, busy); end
            checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL divu_stall[%0d]: got %b want 1", k, stall_md); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_end: got %b want 0", busy); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL divu_stall_end: got %b want 0", stall_md); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 2", hi); end
        md_use_D = 1'b0;
    endtask

    task automatic test_div_signed();
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        repeat (10) tick();
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        issue(3'd3, 32'd5, 32'd0);
        repeat (9) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div0_busy_late: got %b want 1", busy); end
        tick();
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h want 5", hi); end
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (10) tick();
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_mthi_and_ignored_start();
        issue(3'd5, 32'h1234, 32'd0);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h want 1234", hi); end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL mthi_lo: got %h want 80000000", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
        issue(3'd6, 32'hABCD, 32'd0);
        checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_lo: got %h want abcd", lo); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi: got %h want 1234", hi); end
        issue(3'd1, 32'd6, 32'd7);
        tick();
        issue(3'd1, 32'd100, 32'd100);
        repeat (2) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end: got %b want 0", busy); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ign_lo: got %h want 2a", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ign_hi: got %h want 0", hi); end
        repeat (6) tick();
        checks++; if (busy !== 1'b0 || lo !== 32'd42) begin errors++; $display("FAIL ign_late: got busy=%b lo=%h want 0/2a", busy, lo); end
    endtask

    task automatic test_nop_ops();
        md_use_D = 1'b1;
        md_start_E = 1'b1; md_op_E = 3'd0; rs_E = 32'h5555; rt_E = 32'd3;
        #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL nop0_stall: got %b want 0", stall_md); end
        tick();
        md_op_E = 3'd7;
        #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL nop7_stall: got %b want 0", stall_md); end
        tick();
        md_start_E = 1'b0; md_op_E = 3'd0; md_use_D = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL nop_regs: got hi=%h lo=%h want 0/2a", hi, lo); end
    endtask

    task automatic test_reset_mid_run();
        md_use_D = 1'b1;
        issue(3'd1, 32'd3, 32'd3);
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b want 0", stall_md); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL arst_regs: got hi=%h lo=%h want 0/0", hi, lo); end
        #2;
        reset = 1'b1;
        md_use_D = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (busy !== 1'b0 || lo !== 32'd0) begin errors++; $display("FAIL arst_stale[%0d]: got busy=%b lo=%h want 0/0", k, busy, lo); end
        end
    endtask

    task automatic test_multu_no_stall();
        md_use_D = 1'b0;
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL multu_stall[%0d]: got %b want 0", k, stall_md); end
            tick();
        end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 1", lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_stall();
        test_div_signed();
        test_mthi_and_ignored_start();
        test_nop_ops();
        test_reset_mid_run();
        test_multu_no_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
